// File: rtl/multicycle_controller.sv
// Moore control FSM for a shared-memory multicycle MIPS datapath (fetch/decode/execute/mem/wb).
// Latency with an always-ready memory: lw 5, sw/R-type/addi 4, beq/j 3 cycles.
// Memory states hold mem_req and all other outputs until mem_ready; a watchdog traps hung accesses.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       sel_iord,
  output logic       ir_we,
  output logic       pc_en,
  output logic [1:0] sel_pc,
  output logic       sel_alu_a,
  output logic [1:0] sel_alu_b,
  output logic [3:0] alu_ctrl,
  output logic       rf_we,
  output logic [1:0] sel_wa,
  output logic [1:0] sel_result,
  output logic       illegal,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ERROR   = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       sel_iord;
    logic       ir_we;
    logic       pc_en;
    logic [1:0] sel_pc;
    logic       sel_alu_a;
    logic [1:0] sel_alu_b;
    logic [3:0] alu_ctrl;
    logic       rf_we;
    logic [1:0] sel_wa;
    logic [1:0] sel_result;
    logic       illegal;
    logic       err;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t          cur;
  state_t          nxt;
  ctl_t            ctl;
  logic [WD_W-1:0] wd_cnt;
  logic            in_mem;
  logic            wd_hit;

  assign in_mem = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // wd_cnt holds prior stalled cycles, so the current stalled cycle is the TIMEOUT_CYCLES-th one
  assign wd_hit = (TIMEOUT_CYCLES != 0) && in_mem && !mem_ready &&
                  (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cur    <= S_FETCH;
      wd_cnt <= '0;
    end else begin
      cur <= nxt;
      if (!in_mem || mem_ready || (nxt != cur))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_comb begin
    ctl = '0;
    nxt = cur;
    case (cur)
      S_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.sel_alu_b = 2'b01;
        ctl.alu_ctrl  = ALU_ADD;
        ctl.ir_we     = mem_ready;
        ctl.pc_en     = mem_ready;
        nxt           = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctl.sel_alu_b = 2'b11;
        ctl.alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default: begin
            ctl.illegal = 1'b1;
            nxt         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.sel_alu_a = 1'b1;
        ctl.sel_alu_b = 2'b10;
        ctl.alu_ctrl  = ALU_ADD;
        nxt           = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl.mem_req  = 1'b1;
        ctl.sel_iord = 1'b1;
        nxt          = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctl.rf_we      = 1'b1;
        ctl.sel_result = 2'b01;
        nxt            = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_req  = 1'b1;
        ctl.mem_we   = 1'b1;
        ctl.sel_iord = 1'b1;
        nxt          = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ctl.sel_alu_a = 1'b1;
        nxt           = S_ALUWB;
        case (funct)
          6'b100000: ctl.alu_ctrl = ALU_ADD;
          6'b100010: ctl.alu_ctrl = ALU_SUB;
          6'b100100: ctl.alu_ctrl = ALU_AND;
          6'b100101: ctl.alu_ctrl = ALU_OR;
          6'b101010: ctl.alu_ctrl = ALU_SLT;
          default: begin
            ctl.alu_ctrl = ALU_ADD;
            ctl.illegal  = 1'b1;
            nxt          = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        ctl.rf_we  = 1'b1;
        ctl.sel_wa = 2'b01;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        ctl.sel_alu_a = 1'b1;
        ctl.alu_ctrl  = ALU_SUB;
        ctl.sel_pc    = 2'b01;
        ctl.pc_en     = zero;
        nxt           = S_FETCH;
      end
      S_ADDIEX: begin
        ctl.sel_alu_a = 1'b1;
        ctl.sel_alu_b = 2'b10;
        ctl.alu_ctrl  = ALU_ADD;
        nxt           = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.rf_we = 1'b1;
        nxt       = S_FETCH;
      end
      S_JUMP: begin
        ctl.sel_pc = 2'b10;
        ctl.pc_en  = 1'b1;
        nxt        = S_FETCH;
      end
      S_ERROR: begin
        ctl.err = 1'b1;
      end
      default: nxt = S_ERROR;
    endcase
    if (wd_hit)
      nxt = S_ERROR;
  end

  assign {mem_req, mem_we, sel_iord, ir_we, pc_en, sel_pc, sel_alu_a, sel_alu_b,
          alu_ctrl, rf_we, sel_wa, sel_result, illegal, err} = reset ? '0 : ctl;
  assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level model pushes expected per-cycle
// state/outputs into a queue; a negedge monitor pops and compares every cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       sel_iord;
    logic       ir_we;
    logic       pc_en;
    logic [1:0] sel_pc;
    logic       sel_alu_a;
    logic [1:0] sel_alu_b;
    logic [3:0] alu_ctrl;
    logic       rf_we;
    logic [1:0] sel_wa;
    logic [1:0] sel_result;
    logic       illegal;
    logic       err;
  } outs_t;

  typedef struct {
    bit         chk_state;
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                         A_SUB = 4'b0110, A_SLT = 4'b0111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, sel_iord, ir_we, pc_en, sel_alu_a, rf_we, illegal, err;
  logic [1:0] sel_pc, sel_alu_b, sel_wa, sel_result;
  logic [3:0] alu_ctrl, state;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [5:0] cur_op = '0, cur_fn = '0;
  logic       cur_z = 1'b0;

  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .sel_iord(sel_iord),
    .ir_we(ir_we), .pc_en(pc_en), .sel_pc(sel_pc), .sel_alu_a(sel_alu_a),
    .sel_alu_b(sel_alu_b), .alu_ctrl(alu_ctrl), .rf_we(rf_we), .sel_wa(sel_wa),
    .sel_result(sel_result), .illegal(illegal), .err(err), .state(state)
  );

  always #5 clock = ~clock;

  outs_t act;
  assign act = {mem_req, mem_we, sel_iord, ir_we, pc_en, sel_pc, sel_alu_a, sel_alu_b,
                alu_ctrl, rf_we, sel_wa, sel_result, illegal, err};

  // Monitor: one expected record per clock cycle
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_state) begin
        checks++;
        if (state !== e.st) begin
          errors++;
          $display("FAIL state t=%0t got %0d want %0d", $time, state, e.st);
        end
      end
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outs t=%0t st=%0d got %h want %h", $time, state, act, e.o);
      end
    end
  end

  task automatic cyc(input logic rst, input logic mr, input bit chk, input logic [3:0] st,
                     input outs_t o);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; mem_ready = mr; opcode = cur_op; funct = cur_fn; zero = cur_z;
    e.chk_state = chk; e.st = st; e.o = o;
    exp_q.push_back(e);
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Memory access: `waits` stalled cycles, then a completing cycle if `done`
  task automatic mem_phase(input logic [3:0] code, input int waits, input bit done,
                           input logic we, input logic iord, input bit is_fetch);
    outs_t o;
    logic  mr;
    int    n;
    n = done ? waits + 1 : waits;
    for (int i = 0; i < n; i++) begin
      mr = (i == waits);
      o = '0; o.mem_req = 1'b1; o.mem_we = we; o.sel_iord = iord;
      if (is_fetch) begin
        o.sel_alu_b = 2'b01; o.alu_ctrl = A_ADD; o.ir_we = mr; o.pc_en = mr;
      end
      cyc(1'b0, mr, 1'b1, code, o);
    end
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
           op == OP_LW || op == OP_SW;
  endfunction

  // One instruction at ISA level; wm < 0 on lw means reset is asserted mid-read
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int wf, input int wm);
    outs_t o;
    logic [3:0] alu;
    bit ok;
    cur_op = op; cur_fn = fn; cur_z = z;
    mem_phase(4'd0, wf, 1'b1, 1'b0, 1'b0, 1'b1);
    o = '0; o.sel_alu_b = 2'b11; o.alu_ctrl = A_ADD; o.illegal = !legal_op(op);
    cyc(1'b0, rnd_bit(), 1'b1, 4'd1, o);
    if (!legal_op(op)) return;
    if (op == OP_LW || op == OP_SW) begin
      o = '0; o.sel_alu_a = 1'b1; o.sel_alu_b = 2'b10; o.alu_ctrl = A_ADD;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd2, o);
      if (op == OP_SW) begin
        mem_phase(4'd5, wm, 1'b1, 1'b1, 1'b1, 1'b0);
      end else if (wm < 0) begin
        mem_phase(4'd3, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, '0);
      end else begin
        mem_phase(4'd3, wm, 1'b1, 1'b0, 1'b1, 1'b0);
        o = '0; o.rf_we = 1'b1; o.sel_result = 2'b01;
        cyc(1'b0, rnd_bit(), 1'b1, 4'd4, o);
      end
    end else if (op == OP_RTYPE) begin
      ok = 1'b1;
      case (fn)
        6'b100000: alu = A_ADD;
        6'b100010: alu = A_SUB;
        6'b100100: alu = A_AND;
        6'b100101: alu = A_OR;
        6'b101010: alu = A_SLT;
        default: begin alu = A_ADD; ok = 1'b0; end
      endcase
      o = '0; o.sel_alu_a = 1'b1; o.alu_ctrl = alu; o.illegal = !ok;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd6, o);
      if (ok) begin
        o = '0; o.rf_we = 1'b1; o.sel_wa = 2'b01;
        cyc(1'b0, rnd_bit(), 1'b1, 4'd7, o);
      end
    end else if (op == OP_BEQ) begin
      o = '0; o.sel_alu_a = 1'b1; o.alu_ctrl = A_SUB; o.sel_pc = 2'b01; o.pc_en = z;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd8, o);
    end else if (op == OP_ADDI) begin
      o = '0; o.sel_alu_a = 1'b1; o.sel_alu_b = 2'b10; o.alu_ctrl = A_ADD;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd9, o);
      o = '0; o.rf_we = 1'b1;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd10, o);
    end else begin
      o = '0; o.sel_pc = 2'b10; o.pc_en = 1'b1;
      cyc(1'b0, rnd_bit(), 1'b1, 4'd11, o);
    end
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] legal_fn [5];
    logic [5:0] op, fn;
    outs_t o;
    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010; legal_fn[2] = 6'b100100;
    legal_fn[3] = 6'b100101; legal_fn[4] = 6'b101010;

    repeat (3) cyc(1'b1, 1'b1, 1'b0, 4'd0, '0);

    exec_instr(OP_LW, 6'd0, 1'b0, 0, 0);
    exec_instr(OP_SW, 6'd0, 1'b0, 0, 3);
    exec_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    exec_instr(OP_BEQ, 6'd0, 1'b0, 0, 0);
    exec_instr(OP_RTYPE, 6'b101010, 1'b0, 0, 0);
    exec_instr(OP_RTYPE, 6'b111111, 1'b0, 0, 0);
    exec_instr(OP_ADDI, 6'd0, 1'b0, 15, 0);
    exec_instr(OP_J, 6'd0, 1'b0, 1, 0);
    exec_instr(6'b111111, 6'd0, 1'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 6))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_RTYPE;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal_op(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      fn = ($urandom_range(0, 4) != 0) ? legal_fn[$urandom_range(0, 4)]
                                      : 6'($urandom_range(0, 63));
      exec_instr(op, fn, rnd_bit(), rnd_wait(), rnd_wait());
    end

    // Reset while a load is stalled in MEMRD
    exec_instr(OP_LW, 6'd0, 1'b0, 0, -1);
    exec_instr(OP_J, 6'd0, 1'b0, 0, 0);

    // Hung fetch: 16 stalled cycles then ERROR, sticky until reset
    cur_op = OP_J;
    mem_phase(4'd0, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    o = '0; o.err = 1'b1;
    repeat (4) cyc(1'b0, rnd_bit(), 1'b1, 4'd12, o);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, '0);
    exec_instr(OP_ADDI, 6'd0, 1'b0, 0, 0);

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
